burst_addr_seq: RTL and testbench
=================================

BURST_ADDR_SEQ -- requirements
Module: burst_addr_seq

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 24, the width of a beat address.
REQ-002 The block SHALL have parameter LEN_BITS, default 8, the width of the burst length field.
REQ-003 The block SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port i_cmd_valid, input, 1, command request.
REQ-006 The block SHALL have port o_cmd_ready, output, 1, command accepted when high with i_cmd_valid.
REQ-007 The block SHALL have port i_cmd_addr, input, ADDR_BITS, burst start address.
REQ-008 The block SHALL have port i_cmd_len, input, LEN_BITS, burst beats minus one (0 means 1 beat).
REQ-009 The block SHALL have port i_abort, input, 1, terminate the active burst.
REQ-010 The block SHALL have port o_beat_valid, output, 1, beat address available.
REQ-011 The block SHALL have port i_beat_ready, input, 1, downstream consumes the beat when high with o_beat_valid.
REQ-012 The block SHALL have port o_beat_addr, output, ADDR_BITS, current beat address.
REQ-013 The block SHALL have port o_beat_last, output, 1, current beat is the final beat of the burst.
REQ-014 The block SHALL have port o_busy, output, 1, a burst is in progress.
REQ-015 The block SHALL have port o_done, output, 1, one-cycle pulse on normal burst completion.

Function
REQ-016 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-017 o_cmd_ready SHALL be high exactly when in IDLE; o_busy SHALL be high exactly when in RUN.
REQ-018 IDLE -> RUN SHALL occur on the edge where i_cmd_valid and o_cmd_ready are both high; addr and len SHALL be captured on that edge.
REQ-019 i_cmd_valid while in RUN SHALL be ignored; the command is not captured and not queued.
REQ-020 o_beat_valid SHALL be high exactly when in RUN; the first beat SHALL appear the cycle after acceptance with o_beat_addr equal to the captured address.
REQ-021 A beat transfer SHALL be the cycle in which o_beat_valid and i_beat_ready are both high.
REQ-022 o_beat_addr and o_beat_last SHALL remain stable while o_beat_valid is high and i_beat_ready is low.
REQ-023 On each non-final transfer, o_beat_addr SHALL increment by 1 modulo 2^ADDR_BITS (0xFFFFFF wraps to 0x000000 at default width) and the remaining-beat count SHALL decrement by 1.
REQ-024 o_beat_last SHALL be high exactly when the remaining-beat count is 0.
REQ-025 A transfer with o_beat_last high SHALL return the FSM to IDLE and pulse o_done high for exactly the next cycle.
REQ-026 A burst of i_cmd_len = N SHALL produce exactly N+1 transfers; with i_beat_ready tied high it SHALL occupy N+1 consecutive RUN cycles.
REQ-027 i_abort high in RUN SHALL force IDLE on the next edge with no o_done pulse, including when a transfer (last or not) occurs in the same cycle.
REQ-028 A transfer occurring in the abort cycle SHALL be counted as delivered; no further beats SHALL follow.
REQ-029 i_abort in IDLE SHALL have no effect; i_abort and i_cmd_valid together in IDLE SHALL accept the command.
REQ-030 A new command MAY be accepted in the cycle o_done is high, giving back-to-back bursts with a one-cycle gap.
REQ-031 All outputs SHALL be registered or decoded only from the FSM state and internal registers, with no combinational path from any input.

Reset
REQ-032 Asserting i_rst_n low SHALL immediately force IDLE, clear the address and remaining-count registers, and drive o_cmd_ready=1, o_busy=0, o_beat_valid=0, o_beat_last=0, o_beat_addr=0, o_done=0.
REQ-033 Reset asserted mid-burst SHALL discard the burst without an o_done pulse; release SHALL be synchronised to i_clk internally so the first post-reset edge is clean.

Verification
REQ-034 The bench SHALL drive cmd addr=0x000100, len=3, ready tied high -> addrs 0x100, 0x101, 0x102, 0x103 on 4 consecutive cycles, last on 0x103, o_done pulse the next cycle.
REQ-035 The bench SHALL drive addr=0xFFFFFE, len=2 -> addrs 0xFFFFFE, 0xFFFFFF, 0x000000; last on 0x000000.
REQ-036 The bench SHALL drive len=0 with ready low for 5 cycles, then high -> a single beat held stable at its address with last=1 for 6 cycles, one transfer, then o_done.
REQ-037 The bench SHALL drive addr=0x20, len=7 and assert abort after 2 transfers -> IDLE next cycle, no o_done, 3 total transfers if ready was high in the abort cycle.
REQ-038 The bench SHALL hold i_cmd_valid high continuously -> cmd_ready low throughout RUN; the second command is accepted only in the o_done cycle.
REQ-039 The bench SHALL assert i_rst_n low asynchronously mid-burst between clock edges -> outputs reach reset values before the next edge, and no o_done pulse occurs.

Source files
------------

// File: rtl/burst_addr_seq.sv
// Burst address sequencer: accepts a {start address, beats-1} command and
// emits one incrementing beat address per downstream handshake.
module burst_addr_seq #(
  parameter int ADDR_BITS = 24,
  parameter int LEN_BITS  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [ADDR_BITS-1:0] i_cmd_addr,
  input  logic [LEN_BITS-1:0]  i_cmd_len,
  input  logic                 i_abort,
  output logic                 o_beat_valid,
  input  logic                 i_beat_ready,
  output logic [ADDR_BITS-1:0] o_beat_addr,
  output logic                 o_beat_last,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] addr_q;
  logic [LEN_BITS-1:0]  remain_q;
  logic                 done_q;
  logic [1:0]           rst_sync;
  logic                 rst_n_s;

  // NOTE: assertion reaches the core at once through the async clear of the
  // synchroniser; release is delayed two edges so no flop sees a runt edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_s = rst_sync[1];

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge i_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state    <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            addr_q   <= i_cmd_addr;
            remain_q <= i_cmd_len;
            state    <= RUN;
          end
        end
        RUN: begin
          // Abort wins over completion: a beat taken in this cycle still
          // counts as delivered, but no done pulse is raised.
          if (i_abort) begin
            state <= IDLE;
          end else if (i_beat_ready) begin
            if (remain_q == '0) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              addr_q   <= addr_q + 1'b1;
              remain_q <= remain_q - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_cmd_ready  = (state == IDLE);
  assign o_busy       = (state == RUN);
  assign o_beat_valid = (state == RUN);
  assign o_beat_last  = (state == RUN) && (remain_q == '0);
  assign o_beat_addr  = addr_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_burst_addr_seq.sv
// Self-checking bench for burst_addr_seq: scoreboard of expected beats plus
// a vector table and hand-written corner-case sequences.
module tb_burst_addr_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [23:0] i_cmd_addr = '0;
  logic [7:0]  i_cmd_len = '0;
  logic        i_abort = 1'b0;
  logic        o_beat_valid;
  logic        i_beat_ready = 1'b0;
  logic [23:0] o_beat_addr;
  logic        o_beat_last;
  logic        o_busy;
  logic        o_done;

  burst_addr_seq #(.ADDR_BITS(24), .LEN_BITS(8)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_addr   (i_cmd_addr),
    .i_cmd_len    (i_cmd_len),
    .i_abort      (i_abort),
    .o_beat_valid (o_beat_valid),
    .i_beat_ready (i_beat_ready),
    .o_beat_addr  (o_beat_addr),
    .o_beat_last  (o_beat_last),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [23:0] addr;
    logic        last;
  } beat_t;

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  len;
    int          exp_cycles;
  } vec_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    xfer_cnt = 0;
  int    done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream model: every handshake must match the head of the scoreboard.
  always @(negedge i_clk) begin
    if (o_beat_valid && i_beat_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'(o_beat_addr), 32'hDEAD_BEEF);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_addr", 32'(o_beat_addr), 32'(e.addr));
        check("beat_last", 32'(o_beat_last), 32'(e.last));
      end
    end
    if (o_done) done_cnt++;
  end

  task automatic push_exp(input logic [23:0] a, input logic [7:0] l);
    for (int k = 0; k <= int'(l); k++) begin
      beat_t b;
      b.addr = a + 24'(k);
      b.last = (k == int'(l));
      exp_q.push_back(b);
    end
  endtask

  task automatic issue(input logic [23:0] a, input logic [7:0] l);
    int w = 0;
    while (!o_cmd_ready && w < 50) begin
      @(posedge i_clk); #1;
      w++;
    end
    if (!o_cmd_ready) check("issue_ready_timeout", 32'(o_cmd_ready), 32'd1);
    push_exp(a, l);
    i_cmd_valid = 1'b1;
    i_cmd_addr  = a;
    i_cmd_len   = l;
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic run_to_done(output int cycles);
    cycles = 0;
    while (o_busy && cycles < 300) begin
      @(posedge i_clk); #1;
      cycles++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(o_cmd_ready), 32'd1);
    check({tag, "_busy"},      32'(o_busy),      32'd0);
    check({tag, "_valid"},     32'(o_beat_valid), 32'd0);
    check({tag, "_last"},      32'(o_beat_last), 32'd0);
    check({tag, "_addr"},      32'(o_beat_addr), 32'd0);
    check({tag, "_done"},      32'(o_done),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[4];
    int   cyc;
    int   x0;
    int   d0;

    vecs[0] = '{addr: 24'hFFFFFE, len: 8'd2, exp_cycles: 3};
    vecs[1] = '{addr: 24'h000000, len: 8'd0, exp_cycles: 1};
    vecs[2] = '{addr: 24'hABCDEF, len: 8'd5, exp_cycles: 6};
    vecs[3] = '{addr: 24'hFFFFFF, len: 8'd0, exp_cycles: 1};

    // Reset state
    #2;
    check_reset_outputs("reset");
    #21 i_rst_n = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
    check_reset_outputs("post_release");

    // Basic 4-beat burst with ready tied high
    i_beat_ready = 1'b1;
    issue(24'h000100, 8'd3);
    check("b1_first_valid", 32'(o_beat_valid), 32'd1);
    check("b1_first_addr",  32'(o_beat_addr),  32'h100);
    check("b1_cmd_ready_low", 32'(o_cmd_ready), 32'd0);
    run_to_done(cyc);
    check("b1_run_cycles", 32'(cyc), 32'd4);
    check("b1_done_pulse", 32'(o_done), 32'd1);
    @(posedge i_clk); #1;
    check("b1_done_clear", 32'(o_done), 32'd0);
    check("b1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Table-driven bursts, including address wrap and single-beat bursts
    for (int i = 0; i < 4; i++) begin
      d0 = done_cnt;
      issue(vecs[i].addr, vecs[i].len);
      run_to_done(cyc);
      check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cycles));
      check($sformatf("vec%0d_done", i), 32'(o_done), 32'd1);
      @(posedge i_clk); #1;
      check($sformatf("vec%0d_done_count", i), 32'(done_cnt - d0), 32'd1);
      check($sformatf("vec%0d_queue_empty", i), 32'(exp_q.size()), 32'd0);
    end

    // Single beat held under backpressure for 5 cycles
    i_beat_ready = 1'b0;
    x0 = xfer_cnt;
    issue(24'h000055, 8'd0);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(o_beat_valid), 32'd1);
      check("hold_addr",  32'(o_beat_addr),  32'h55);
      check("hold_last",  32'(o_beat_last),  32'd1);
      @(posedge i_clk); #1;
    end
    i_beat_ready = 1'b1;
    check("hold6_addr", 32'(o_beat_addr), 32'h55);
    check("hold6_last", 32'(o_beat_last), 32'd1);
    @(posedge i_clk); #1;
    check("hold_busy_after", 32'(o_busy), 32'd0);
    check("hold_done", 32'(o_done), 32'd1);
    check("hold_xfers", 32'(xfer_cnt - x0), 32'd1);

    // Abort after two transfers with ready high in the abort cycle
    @(posedge i_clk); #1;
    x0 = xfer_cnt;
    d0 = done_cnt;
    issue(24'h000020, 8'd7);
    repeat (2) @(posedge i_clk);
    #1;
    i_abort = 1'b1;
    @(posedge i_clk); #1;
    i_abort = 1'b0;
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_cmd_ready", 32'(o_cmd_ready), 32'd1);
    check("abort_no_done", 32'(o_done), 32'd0);
    @(posedge i_clk); #1;
    check("abort_done_count", 32'(done_cnt - d0), 32'd0);
    check("abort_xfers", 32'(xfer_cnt - x0), 32'd3);
    check("abort_beats_left", 32'(exp_q.size()), 32'd5);
    exp_q.delete();

    // Abort together with a command in IDLE is ignored; command accepted
    i_abort = 1'b1;
    issue(24'h000077, 8'd0);
    i_abort = 1'b0;
    check("idle_abort_accept", 32'(o_busy), 32'd1);
    run_to_done(cyc);
    check("idle_abort_done", 32'(o_done), 32'd1);

    // Valid held high: second command only taken in the done cycle
    @(posedge i_clk); #1;
    push_exp(24'h000300, 8'd1);
    i_cmd_valid = 1'b1;
    i_cmd_addr  = 24'h000300;
    i_cmd_len   = 8'd1;
    @(posedge i_clk); #1;
    i_cmd_addr  = 24'h000400;
    i_cmd_len   = 8'd2;
    check("bb_run_ready0", 32'(o_cmd_ready), 32'd0);
    @(posedge i_clk); #1;
    check("bb_run_ready1", 32'(o_cmd_ready), 32'd0);
    check("bb_run_last",   32'(o_beat_last), 32'd1);
    @(posedge i_clk); #1;
    check("bb_gap_done",  32'(o_done), 32'd1);
    check("bb_gap_ready", 32'(o_cmd_ready), 32'd1);
    check("bb_gap_busy",  32'(o_busy), 32'd0);
    push_exp(24'h000400, 8'd2);
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
    check("bb_second_busy", 32'(o_busy), 32'd1);
    check("bb_second_addr", 32'(o_beat_addr), 32'h400);
    run_to_done(cyc);
    check("bb_second_cycles", 32'(cyc), 32'd3);
    @(posedge i_clk); #1;
    check("bb_queue_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-burst, between clock edges
    d0 = done_cnt;
    issue(24'h000500, 8'd7);
    repeat (2) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("rst_idle", 32'(o_cmd_ready), 32'd1);

    // Recovery after reset
    issue(24'h000A00, 8'd1);
    run_to_done(cyc);
    check("recover_cycles", 32'(cyc), 32'd2);
    check("recover_done", 32'(o_done), 32'd1);
    @(posedge i_clk); #1;
    check("recover_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
